// File: rtl/chaos_pkg.sv
// Shared definitions for the chaos keystream generator family.
// Holds the FSM state encoding, default widths, the fixed-point 1.0 constant
// and a default-width logistic step function for legacy and model users.
package chaos_pkg;

    localparam int unsigned CHAOS_XW       = 16;
    localparam int unsigned CHAOS_OUT_W    = 32;
    localparam int unsigned CHAOS_BURN_MAX = 255;
    localparam int unsigned CHAOS_CNT_W    = 16;
    localparam int unsigned CHAOS_PW       = 2 * CHAOS_XW + 1;

    // Fixed-point 1.0 (2^XW); needs one bit more than the state itself.
    localparam logic [CHAOS_XW:0] ONE_FX = {1'b1, {CHAOS_XW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BURN = 2'd1,
        FILL = 2'd2,
        HOLD = 2'd3
    } chaos_state_e;

    // x_next = 4*x*(1-x) in fixed point, saturating at all-ones instead of wrapping.
    function automatic logic [CHAOS_XW-1:0] logistic_step_f(input logic [CHAOS_XW-1:0] x);
        logic [CHAOS_PW-1:0] p;
        logic [CHAOS_PW-1:0] r;
        p = CHAOS_PW'(x) * (CHAOS_PW'(ONE_FX) - CHAOS_PW'(x));
        r = p >> (CHAOS_XW - 2);
        if (r >= CHAOS_PW'(ONE_FX)) begin
            return '1;
        end
        return r[CHAOS_XW-1:0];
    endfunction

endpackage

// File: rtl/logistic_step.sv
// Combinational logistic-map iteration x -> 4*x*(1-x) in XW-bit fixed point.
// Ports: x (current state), x_next_c (next state, saturated to 2^XW-1).
module logistic_step
    import chaos_pkg::*;
#(
    parameter int unsigned XW = CHAOS_XW
) (
    input  logic [XW-1:0] x,
    output logic [XW-1:0] x_next_c
);

    localparam int unsigned PW  = 2 * XW + 1;
    localparam logic [PW-1:0] ONE = PW'(1) << XW;

    logic [PW-1:0] prod_c;
    logic [PW-1:0] scaled_c;

    // Product kept at full width; x = 1/2 lands exactly on 1.0 and must saturate.
    always_comb begin
        prod_c   = PW'(x) * (ONE - PW'(x));
        scaled_c = prod_c >> (XW - 2);
        x_next_c = (scaled_c >= ONE) ? '1 : scaled_c[XW-1:0];
    end

endmodule

// File: rtl/chaos_keystream_gen.sv
// Logistic-map keystream generator: accepts a seed/burn/word-count config,
// discards burn iterations, then packs one MSB per iteration into OUT_W-bit
// words streamed over valid/ready.
// Ports: cfg_* (config handshake), ks_* (keystream handshake + last marker),
// abort (synchronous cancel), busy, err_degenerate (sticky zero-state flag).
module chaos_keystream_gen
    import chaos_pkg::*;
#(
    parameter int unsigned XW       = CHAOS_XW,
    parameter int unsigned OUT_W    = CHAOS_OUT_W,
    parameter int unsigned BURN_MAX = CHAOS_BURN_MAX,
    parameter int unsigned CNT_W    = CHAOS_CNT_W,
    localparam int unsigned BW      = $clog2(BURN_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XW-1:0]    cfg_x0,
    input  logic [BW-1:0]    cfg_burn,
    input  logic [CNT_W-1:0] cfg_words,
    input  logic             cfg_vld,
    output logic             cfg_rdy,
    output logic [OUT_W-1:0] ks_data,
    output logic             ks_vld,
    input  logic             ks_rdy,
    output logic             ks_last,
    input  logic             abort,
    output logic             busy,
    output logic             err_degenerate
);

    localparam int unsigned BCW = $clog2(OUT_W);

    chaos_state_e     state_q, state_d;
    logic [XW-1:0]    x_q, x_d, x_next_c;
    logic [BW-1:0]    burn_cnt_q, burn_cnt_d;
    logic [CNT_W-1:0] words_left_q, words_left_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [OUT_W-1:0] shreg_q, shreg_d, shifted_c;
    logic [OUT_W-1:0] ks_data_q, ks_data_d;
    logic             ks_vld_q, ks_vld_d;
    logic             ks_last_q, ks_last_d;
    logic             cfg_rdy_q, cfg_rdy_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             seed_err_q, seed_err_d;
    logic             cfg_accept_c;

    logistic_step #(.XW(XW)) u_step (
        .x        (x_q),
        .x_next_c (x_next_c)
    );

    // First generated bit ends up at the MSB after OUT_W shifts.
    assign shifted_c    = {shreg_q[OUT_W-2:0], x_next_c[XW-1]};
    assign cfg_accept_c = cfg_vld & cfg_rdy_q & ~abort;

    // Next-state, counters, datapath and registered outputs.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        burn_cnt_d   = burn_cnt_q;
        words_left_d = words_left_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        ks_data_d    = ks_data_q;
        ks_vld_d     = ks_vld_q;
        ks_last_d    = ks_last_q;
        err_d        = err_q;
        seed_err_d   = 1'b0;

        // A zero-seed rejection only flags for a single cycle.
        if (seed_err_q) begin
            err_d = 1'b0;
        end

        if (abort) begin
            state_d   = IDLE;
            ks_vld_d  = 1'b0;
            ks_last_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_accept_c) begin
                        if (cfg_x0 == '0) begin
                            err_d      = 1'b1;
                            seed_err_d = 1'b1;
                        end else begin
                            x_d          = cfg_x0;
                            burn_cnt_d   = cfg_burn;
                            words_left_d = (cfg_words == '0) ? CNT_W'(1) : cfg_words;
                            bit_cnt_d    = '0;
                            err_d        = 1'b0;
                            state_d      = (cfg_burn != '0) ? BURN : FILL;
                        end
                    end
                end
                BURN: begin
                    x_d = x_next_c;
                    if (x_next_c == '0) begin
                        err_d = 1'b1;
                    end
                    if (burn_cnt_q != '0) begin
                        burn_cnt_d = burn_cnt_q - BW'(1);
                    end
                    if (burn_cnt_q <= BW'(1)) begin
                        bit_cnt_d = '0;
                        state_d   = FILL;
                    end
                end
                FILL: begin
                    x_d     = x_next_c;
                    shreg_d = shifted_c;
                    if (x_next_c == '0) begin
                        err_d = 1'b1;
                    end
                    if (bit_cnt_q == BCW'(OUT_W - 1)) begin
                        ks_data_d = shifted_c;
                        ks_vld_d  = 1'b1;
                        ks_last_d = (words_left_q == CNT_W'(1));
                        state_d   = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
                HOLD: begin
                    if (ks_vld_q && ks_rdy) begin
                        ks_vld_d  = 1'b0;
                        ks_last_d = 1'b0;
                        if (words_left_q > CNT_W'(1)) begin
                            words_left_d = words_left_q - CNT_W'(1);
                            bit_cnt_d    = '0;
                            state_d      = FILL;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        cfg_rdy_d = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            burn_cnt_q   <= '0;
            words_left_q <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            ks_data_q    <= '0;
            ks_vld_q     <= 1'b0;
            ks_last_q    <= 1'b0;
            cfg_rdy_q    <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            seed_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            burn_cnt_q   <= burn_cnt_d;
            words_left_q <= words_left_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            ks_data_q    <= ks_data_d;
            ks_vld_q     <= ks_vld_d;
            ks_last_q    <= ks_last_d;
            cfg_rdy_q    <= cfg_rdy_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            seed_err_q   <= seed_err_d;
        end
    end

    assign cfg_rdy        = cfg_rdy_q;
    assign ks_data        = ks_data_q;
    assign ks_vld         = ks_vld_q;
    assign ks_last        = ks_last_q;
    assign busy           = busy_q;
    assign err_degenerate = err_q;

endmodule
